// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: base^exp mod M by left-to-right square-and-multiply over an external Montgomery multiplier.
// Optional build macro MOD_EXP_SKIP_LZ_EN skips leading-zero exponent bits before the first squaring.
module mod_exp_ctrl #(
   parameter int           K    = 192,
   parameter int           LOGK = 8,
   parameter logic [K-1:0] M    = 192'hffffffffffffffff_fffffffffffffffe_ffffffffffffffff,
   parameter logic [K-1:0] R2   = 192'h0000000000000001_0000000000000002_0000000000000001
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [K-1:0] base,
   input  logic [K-1:0] exp,
   output logic [K-1:0] result,
   output logic         done,
   output logic         busy,
   output logic [K-1:0] mm_x,
   output logic [K-1:0] mm_y,
   output logic         mm_start,
   input  logic [K-1:0] mm_z,
   input  logic         mm_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_NEXT, S_SKIP, S_FIN
   } state_t;

   typedef enum logic [2:0] {
      OP_TOB, OP_TOA, OP_SQR, OP_MUL, OP_FRM
   } op_t;

   localparam logic [K-1:0]    ONE     = K'(1);
   localparam logic [LOGK-1:0] IDX_TOP = LOGK'(K - 1);

   // Montgomery reduction needs an odd modulus and a reduced conversion constant.
   if (M[0] == 1'b0) begin : g_even_modulus
      $error("mod_exp_ctrl: modulus M must be odd");
   end
   if (R2 >= M) begin : g_unreduced_r2
      $error("mod_exp_ctrl: R2 must be reduced below M");
   end

   state_t          state;
   op_t             op;
   logic [K-1:0]    base_r;
   logic [K-1:0]    exp_r;
   logic [K-1:0]    bm;
   logic [K-1:0]    a;
   logic [LOGK-1:0] idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         op       <= OP_TOB;
         base_r   <= '0;
         exp_r    <= '0;
         bm       <= '0;
         a        <= '0;
         idx      <= IDX_TOP;
         result   <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
         mm_x     <= '0;
         mm_y     <= '0;
         mm_start <= 1'b0;
      end else begin
         mm_start <= 1'b0;
         done     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  base_r <= base;
                  exp_r  <= exp;
                  op     <= OP_TOB;
                  idx    <= IDX_TOP;
                  busy   <= 1'b1;
                  state  <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               case (op)
                  OP_TOB: begin
                     mm_x <= base_r;
                     mm_y <= R2;
                  end
                  OP_TOA: begin
                     mm_x <= R2;
                     mm_y <= ONE;
                  end
                  OP_SQR: begin
                     mm_x <= a;
                     mm_y <= a;
                  end
                  OP_MUL: begin
                     mm_x <= a;
                     mm_y <= bm;
                  end
                  default: begin
                     mm_x <= a;
                     mm_y <= ONE;
                  end
               endcase
               mm_start <= 1'b1;
               state    <= S_WAIT_LO;
            end

            // mm_done may still be high from the previous op until the multiplier loads the new one.
            S_WAIT_LO: begin
               if (!mm_done) state <= S_WAIT_HI;
            end

            S_WAIT_HI: begin
               if (mm_done) begin
                  if (op == OP_TOB) bm <= mm_z;
                  else              a  <= mm_z;
                  state <= S_NEXT;
               end
            end

            S_NEXT: begin
               state <= S_ISSUE;
               case (op)
                  OP_TOB: op <= OP_TOA;
                  OP_TOA: begin
`ifdef MOD_EXP_SKIP_LZ_EN
                     state <= S_SKIP;
`else
                     op <= OP_SQR;
`endif
                  end
                  OP_SQR, OP_MUL: begin
                     if (op == OP_SQR && exp_r[idx]) begin
                        op <= OP_MUL;
                     end else if (idx == '0) begin
                        op <= OP_FRM;
                     end else begin
                        idx <= idx - LOGK'(1);
                        op  <= OP_SQR;
                     end
                  end
                  default: begin
                     result <= a;
                     done   <= 1'b1;
                     state  <= S_FIN;
                  end
               endcase
            end

            // With A = R, the square and multiply on the top set bit reduce to A = Bm.
            S_SKIP: begin
`ifdef MOD_EXP_SKIP_LZ_EN
               if (exp_r[idx]) begin
                  a     <= bm;
                  state <= S_ISSUE;
                  if (idx == '0) begin
                     op <= OP_FRM;
                  end else begin
                     idx <= idx - LOGK'(1);
                     op  <= OP_SQR;
                  end
               end else if (idx == '0) begin
                  op    <= OP_FRM;
                  state <= S_ISSUE;
               end else begin
                  idx <= idx - LOGK'(1);
               end
`else
               state <= S_IDLE;
`endif
            end

            S_FIN: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
